// File: rtl/wdog_timer.sv
// Watchdog timer: counts down from a programmed timeout and, if it is not kicked in time,
// drives a fixed-length active-low reset request and latches a sticky expired flag.
module wdog_timer #(
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned WARN_CYCLES = 1024,
  parameter int unsigned PULSE_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 kick,
  input  logic [CNT_WIDTH-1:0] timeout,
  input  logic                 clr,
  output logic                 rst_req_n,
  output logic                 warn,
  output logic                 expired,
  output logic                 running
);

  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0]        PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] WARN_TH    = CNT_WIDTH'(WARN_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [PW-1:0]        pcnt;
  logic [PW-1:0]        pcnt_nxt;
  logic                 fire_done;
  logic [CNT_WIDTH-1:0] load_val;

  // A zero timeout is clamped to one so the counter always spends a cycle above zero.
  assign load_val = (timeout == '0) ? CNT_WIDTH'(1) : timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcnt_nxt  = pcnt;
    fire_done = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        pcnt_nxt = '0;
        if (en) begin
          state_nxt = RUN;
          cnt_nxt   = load_val;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (kick) begin
          cnt_nxt = load_val;
        end else if (cnt == '0) begin
          state_nxt = FIRE;
          pcnt_nxt  = PULSE_LAST;
        end else begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end
      end
      FIRE: begin
        cnt_nxt = '0;
        if (pcnt == '0) begin
          state_nxt = IDLE;
          fire_done = 1'b1;
        end else begin
          pcnt_nxt = pcnt - PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pcnt      <= '0;
      rst_req_n <= 1'b1;
      warn      <= 1'b0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      pcnt      <= pcnt_nxt;
      rst_req_n <= (state_nxt != FIRE);
      running   <= (state_nxt == RUN);
      warn      <= (state_nxt == RUN) && (cnt_nxt <= WARN_TH);
      if (fire_done) begin
        expired <= 1'b1;
      end else if (clr) begin
        expired <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wdog_timer.sv
// Bench for wdog_timer: vector table, directed corner sequences and random traffic
// checked against a deadline-based model of the watchdog.
module tb_wdog_timer;

  localparam int unsigned CW   = 24;
  localparam int unsigned WARN = 4;
  localparam int unsigned PL   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          kick = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] timeout = '0;
  logic          rst_req_n;
  logic          warn;
  logic          expired;
  logic          running;

  wdog_timer #(.CNT_WIDTH(CW), .WARN_CYCLES(WARN), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .en(en), .kick(kick), .timeout(timeout), .clr(clr),
    .rst_req_n(rst_req_n), .warn(warn), .expired(expired), .running(running)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: t is the index of the current cycle; in RUN the counter equals deadline - t,
  // and FIRE lasts until the edge numbered fire_end.
  longint t = 0;
  longint deadline = 0;
  longint fire_end = 0;
  int     phase = 0;
  bit     m_exp = 1'b0;
  bit     m_req_n = 1'b1;
  bit     m_warn = 1'b0;
  bit     m_run = 1'b0;

  task automatic model_edge(input bit r, input bit e, input bit k, input bit c,
                            input logic [CW-1:0] to);
    longint ld;
    bit     set;
    ld  = (to == 0) ? 1 : longint'(to);
    set = 1'b0;
    if (r) begin
      phase = 0;
      m_exp = 1'b0;
    end else begin
      case (phase)
        0: if (e) begin phase = 1; deadline = t + 1 + ld; end
        1: begin
          if (!e) phase = 0;
          else if (k) deadline = t + 1 + ld;
          else if (deadline == t) begin phase = 2; fire_end = t + PL; end
        end
        default: if (t == fire_end) begin phase = 0; set = 1'b1; end
      endcase
      if (set) m_exp = 1'b1;
      else if (c) m_exp = 1'b0;
    end
    t++;
    m_run   = (phase == 1);
    m_req_n = (phase != 2);
    m_warn  = (phase == 1) && ((deadline - t) <= longint'(WARN));
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit k, input bit c,
                      input logic [CW-1:0] to);
    rst = r; en = e; kick = k; clr = c; timeout = to;
    @(posedge clk);
    model_edge(r, e, k, c, to);
    #1;
    chk("model.rst_req_n", rst_req_n, m_req_n);
    chk("model.warn", warn, m_warn);
    chk("model.expired", expired, m_exp);
    chk("model.running", running, m_run);
  endtask

  typedef struct {
    bit          r, e, k, c;
    logic [CW-1:0] to;
    bit          x_req_n, x_warn, x_exp, x_run;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Reset, arm with 6, warn at 4, kick reload, disarm, clamp 0->1, kick to 3, fire.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd9, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd3, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'd6, 1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].k, tbl[i].c, tbl[i].to);
      chk("tbl.rst_req_n", rst_req_n, tbl[i].x_req_n);
      chk("tbl.warn", warn, tbl[i].x_warn);
      chk("tbl.expired", expired, tbl[i].x_exp);
      chk("tbl.running", running, tbl[i].x_run);
    end

    // Reset check: 3 cycles of rst, then 100 idle cycles.
    for (int i = 0; i < 103; i++) begin
      step(i < 3, 1'b0, 1'b0, 1'b0, 24'd0);
      chk("rst.rst_req_n", rst_req_n, 1'b1);
      chk("rst.warn", warn, 1'b0);
      chk("rst.expired", expired, 1'b0);
      chk("rst.running", running, 1'b0);
    end

    // No-kick expiry with timeout 10 (also the warn threshold at 4).
    for (int c = 0; c < 30; c++) begin
      int ca;
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10);
      ca = c + 1;
      chk("expiry.rst_req_n", rst_req_n, !(ca >= 12 && ca <= 27));
      chk("expiry.warn", warn, (ca >= 7 && ca <= 11));
      chk("expiry.expired", expired, (ca >= 28));
      chk("expiry.running", running, ((ca >= 1 && ca <= 11) || ca >= 29));
    end

    // Disarm mid-RUN: IDLE next cycle and no pulse afterwards.
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'd10);
    chk("disarm.running", running, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'd10);
      chk("disarm.rst_req_n", rst_req_n, 1'b1);
    end

    // Timeout 0 clamps to 1: pulse starts 3 cycles after the arming edge.
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
      chk("clamp.rst_req_n", rst_req_n, (c < 2));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    // Kick every 8 cycles keeps it alive.
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10);
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, (i % 8) == 7, 1'b0, 24'd10);
      chk("keepalive.rst_req_n", rst_req_n, 1'b1);
    end

    // Kick on the counter==0 cycle prevents FIRE.
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'd10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 24'd10);
    chk("kick0.rst_req_n", rst_req_n, 1'b1);
    chk("kick0.running", running, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10);
      chk("kick0.hold", rst_req_n, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'd10);

    // clr alone, then clr racing the FIRE->IDLE set.
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
    chk("clr.expired", expired, 1'b0);
    for (int s = 0; s < 19; s++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'd2);
    chk("race.pre_rst_req_n", rst_req_n, 1'b0);
    chk("race.pre_expired", expired, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 24'd2);
    chk("race.expired", expired, 1'b1);
    chk("race.rst_req_n", rst_req_n, 1'b1);

    // rst during the 5th FIRE cycle.
    for (int s = 0; s < 7; s++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    chk("midfire.low", rst_req_n, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'd0);
    chk("midfire.rst_req_n", rst_req_n, 1'b1);
    chk("midfire.expired", expired, 1'b0);
    chk("midfire.running", running, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, e, k, c;
      logic [CW-1:0] to;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 19) != 0);
      k  = ($urandom_range(0, 15) == 0);
      c  = ($urandom_range(0, 19) == 0);
      to = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(4, 40));
      step(r, e, k, c, to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wdog_timer.md
# wdog_timer

Watchdog timer and reset-request source for the board's clock/reset generator. Software or a supervising FSM must kick it periodically; if the programmed timeout elapses without a kick, the block drives an active-low reset-request pulse. That pulse feeds the generator's external reset input (`rst_in_n`), restarting the reset sequence for the whole design. The block runs in the 50 MHz domain and is itself reset by the generator's `rst`.

## Interface
- `CNT_WIDTH`, 24, width of timeout counter and `timeout` input.
- `WARN_CYCLES`, 1024, `warn` asserts while remaining count ≤ this value.
- `PULSE_LEN`, 16, cycles `rst_req_n` is held low; legal range ≥ 4.
- `clk` input 1: 50 MHz system clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: 1 = watchdog armed; 0 = disarmed.
- `kick` input 1: single-cycle strobe that reloads the counter.
- `timeout` input CNT_WIDTH: timeout in cycles, sampled on arming and on every accepted kick.
- `clr` input 1: clears the sticky `expired` flag.
- `rst_req_n` output 1: active-low reset request to the generator's `rst_in_n`.
- `warn` output 1: early warning; remaining count is at or below WARN_CYCLES.
- `expired` output 1: sticky flag; a timeout has fired since the last clear.
- `running` output 1: 1 while in RUN.

## Operation
- States: IDLE, RUN, FIRE.
- IDLE: counter = 0, `rst_req_n` = 1, `warn` = 0.
  - `en` = 1 → RUN; counter loads `timeout`, with 0 clamped to 1.
- RUN: counter decrements by 1 per cycle. Priority, highest first:
  - `en` = 0 → IDLE, counter cleared.
  - `kick` = 1 → counter reloads `timeout` (0 clamps to 1); stay in RUN.
  - counter == 0 → FIRE; pulse counter loads PULSE_LEN−1.
  - otherwise decrement.
- FIRE:
  - `rst_req_n` = 0; pulse counter decrements.
  - At pulse counter == 0 → IDLE, `rst_req_n` returns to 1, `expired` sets to 1.
  - `en`, `kick` and `timeout` are ignored in FIRE.
- `expired`:
  - Sets on the FIRE→IDLE transition; cleared by `clr` or `rst`.
  - If `clr` and set occur in the same cycle, set wins.
- `warn`:
  - Registered; 1 in RUN when the next counter value is ≤ WARN_CYCLES.
  - 0 in IDLE and FIRE.
- Arithmetic:
  - Counter is unsigned CNT_WIDTH and never wraps; a decrement is suppressed at 0.
  - Pulse counter width is ceil(log2(PULSE_LEN)).
- Re-arm: if `en` is still 1 on return to IDLE, the block enters RUN on the following cycle with a fresh load.

## Timing
- All outputs are registered. Reset values:
  - `rst_req_n` = 1
  - `warn` = 0
  - `expired` = 0
  - `running` = 0
  - state IDLE, counters 0
- Arm latency: `en` high in cycle n → `running` = 1 in cycle n+1.
- Expiry latency: with no kick and timeout T ≥ 1, the first cycle with `rst_req_n` = 0 is T+2 cycles after the arming edge. That is the RUN entry cycle plus T+1 cycles.
- `rst_req_n` is low for exactly PULSE_LEN consecutive cycles; there are no glitches and it is never low outside FIRE.
- Reset in any state:
  - Returns to IDLE next edge and `rst_req_n` = 1 immediately.
  - The generator's reset, caused by our own pulse, truncating FIRE is expected and legal. PULSE_LEN ≥ 4 guarantees the generator's 2-flop synchronizer has captured the request by then.
- A kick in the same cycle the counter reaches 0 prevents FIRE.

## Test plan
- Reset check: drive `rst`=1 for 3 cycles, then 0 with `en`=0 for 100 cycles → `rst_req_n`=1, `warn`=0, `expired`=0 and `running`=0 throughout.
- No-kick expiry: `timeout`=10, `en`=1 at cycle 0, no kicks →
  - `running`=1 at cycle 1.
  - `rst_req_n` low for cycles 12–27 (PULSE_LEN=16).
  - `expired`=1 from cycle 28.
  - Re-enters RUN at cycle 29.
- Kick keeps alive: `timeout`=10, kick every 8 cycles for 1000 cycles → `rst_req_n` never low. Then a kick exactly on the counter==0 cycle → no FIRE.
- Warn threshold: `WARN_CYCLES`=4, `timeout`=10, no kick → `warn` rises when the counter next equals 4, stays 1 through counter 0, and drops on entry to FIRE.
- Disarm and clamp:
  - `en` dropped mid-RUN → IDLE next cycle, no pulse.
  - `timeout`=0 on arming → treated as 1; pulse begins 3 cycles after the arming edge.
- Clear/set race and mid-FIRE reset:
  - `clr` asserted on the FIRE→IDLE cycle → `expired`=1.
  - `rst` asserted in the 5th FIRE cycle → `rst_req_n`=1 next cycle, `expired`=0.
